// File: rtl/bcd_serial_addsub_if.sv
// Operand/result handshake bundle for bcd_serial_addsub.
//   in_valid/in_ready   : operand set transfer (a, b, sub, cin)
//   out_valid/out_ready : result transfer (sum, cout, bad_digit)
// master = producer/consumer side, slave = the adder/subtractor.
interface bcd_serial_addsub_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  sub;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  bad_digit;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, bad_digit
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, bad_digit
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one decimal digit per clock,
// least-significant digit first (binary add + 6 correction per digit).
// Subtraction uses the nine's complement of B with an initial carry of 1,
// giving ten's complement results; cout=1 then means "no borrow".
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    slave side of bcd_serial_addsub_if:
//          in_valid/in_ready, a, b, sub, cin  -> operand transfer
//          out_valid/out_ready, sum, cout, bad_digit -> result transfer
module bcd_serial_addsub #(
  parameter int unsigned DIGITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_serial_addsub_if.slave bus
);

  localparam int unsigned W    = 4 * DIGITS;
  localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      sum_q;
  logic              sub_q;
  logic              carry_q;
  logic              cout_q;
  logic              bad_q;
  logic [IDXW-1:0]   idx;

  logic              last;
  logic [3:0]        a_d;
  logic [3:0]        b_d;
  logic [3:0]        bd;
  logic [4:0]        t;
  logic [3:0]        digit;
  logic              carry_nxt;
  logic              bad_now;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (last)         state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.bad_digit = bad_q;

  // Single-digit decimal adder on the digit selected by idx
  always_comb begin
    last      = (idx == IDXW'(DIGITS - 1));
    a_d       = a_q[{idx, 2'b00} +: 4];
    b_d       = b_q[{idx, 2'b00} +: 4];
    bd        = sub_q ? (4'd9 - b_d) : b_d;
    t         = {1'b0, a_d} + {1'b0, bd} + {4'd0, carry_q};
    bad_now   = (a_d > 4'd9) | (b_d > 4'd9);
    if (t > 5'd9) begin
      digit     = t[3:0] + 4'd6;
      carry_nxt = 1'b1;
    end else begin
      digit     = t[3:0];
      carry_nxt = 1'b0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      bad_q   <= 1'b0;
      idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            sub_q   <= bus.sub;
            carry_q <= bus.sub | bus.cin;
            bad_q   <= 1'b0;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= digit;
          carry_q <= carry_nxt;
          bad_q   <= bad_q | bad_now;
          idx     <= idx + IDXW'(1);
          if (last) cout_q <= carry_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_addsub.sv
module tb_bcd_serial_addsub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bcd_serial_addsub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Decimal reference: plain integer arithmetic modulo 10^DIGITS
  task automatic ref_model(input int unsigned av, input int unsigned bv,
                           input logic s, input logic c,
                           output logic [W-1:0] es, output logic ec);
    int unsigned p;
    int unsigned tot;
    p = 1;
    for (int i = 0; i < DIGITS; i++) p = p * 10;
    if (!s) begin
      tot = av + bv + int'(c);
      ec  = (tot >= p);
      es  = to_bcd(tot % p);
    end else if (av >= bv) begin
      es = to_bcd(av - bv);
      ec = 1'b1;
    end else begin
      es = to_bcd(p - (bv - av));
      ec = 1'b0;
    end
  endtask

  function automatic logic any_bad(input logic [W-1:0] x);
    logic r;
    r = 1'b0;
    for (int i = 0; i < DIGITS; i++) if (x[4*i +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  // One full transaction; hold = cycles out_ready stays low in DONE
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s, input logic c, input int hold,
                        output logic [W-1:0] gsum, output logic gcout,
                        output logic gbad);
    int cyc;
    @(negedge clk);
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = av; bus.b = bv; bus.sub = s; bus.cin = c; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_run", 32'(bus.in_ready), 32'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 4 * DIGITS + 8) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", 32'(cyc), 32'(DIGITS));
    gsum  = bus.sum;
    gcout = bus.cout;
    gbad  = bus.bad_digit;
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = (k == 0);
      bus.a = ~av;
      @(negedge clk);
      check("hold_sum",   32'(bus.sum), 32'(gsum));
      check("hold_cout",  32'(bus.cout), 32'(gcout));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_rdy",   32'(bus.in_ready), 32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("rdy_after_done", 32'(bus.in_ready), 32'd1);
    check("valid_after_done", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic check_dec(input string tag, input int unsigned av, input int unsigned bv,
                           input logic s, input logic c, input int hold);
    logic [W-1:0] es, gs;
    logic ec, gc, gb;
    ref_model(av, bv, s, c, es, ec);
    run_op(to_bcd(av), to_bcd(bv), s, c, hold, gs, gc, gb);
    check({tag, "_sum"},  32'(gs), 32'(es));
    check({tag, "_cout"}, 32'(gc), 32'(ec));
    check({tag, "_bad"},  32'(gb), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] gs, ra, rb;
    logic gc, gb;
    int t0, t1, t2, cyc;

    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum), 32'd0);
    check("rst_cout",      32'(bus.cout), 32'd0);
    check("rst_bad",       32'(bus.bad_digit), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    check_dec("t1_add",     1234, 8766, 1'b0, 1'b0, 0);
    check_dec("t2_ripple",  9999,    0, 1'b0, 1'b1, 0);
    check_dec("t2_zero",       0,    0, 1'b0, 1'b0, 0);
    check_dec("t3_sub_pos", 5000, 1234, 1'b1, 1'b0, 0);
    check_dec("t3_sub_neg", 1234, 5000, 1'b1, 1'b0, 0);
    check_dec("t3_sub_eq",    42,   42, 1'b1, 1'b1, 0);

    // Invalid digit: 12A4 + 0001 -> 1305, no carry, flagged
    run_op(16'h12A4, 16'h0001, 1'b0, 1'b0, 0, gs, gc, gb);
    check("t4_bad",  32'(gb), 32'd1);
    check("t4_sum",  32'(gs), 32'h1305);
    check("t4_cout", 32'(gc), 32'd0);
    check_dec("t4_clear", 1, 1, 1'b0, 1'b0, 0);

    // Back-pressure in DONE with a stray in_valid pulse
    check_dec("t5_hold", 4321, 5678, 1'b0, 1'b1, 10);

    // Back-to-back throughput with out_ready tied high
    @(negedge clk);
    bus.a = to_bcd(1111); bus.b = to_bcd(2222); bus.sub = 1'b0; bus.cin = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    t0 = -1; t1 = -1; t2 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("t5_b2b_sum", 32'(bus.sum), 32'(to_bcd(3333)));
        if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
      end
    end
    check("t5_period1", 32'(t1 - t0), 32'(DIGITS + 2));
    check("t5_period2", 32'(t2 - t1), 32'(DIGITS + 2));
    bus.in_valid = 1'b0;
    repeat (2 * DIGITS + 4) @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset while handling digit 2
    @(negedge clk);
    bus.a = to_bcd(9999); bus.b = to_bcd(9999); bus.sub = 1'b0; bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_in_ready",  32'(bus.in_ready), 32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_sum",       32'(bus.sum), 32'd0);
    cyc = 0;
    repeat (DIGITS + 2) begin
      @(negedge clk);
      if (bus.out_valid) cyc++;
    end
    check("t6_no_result", 32'(cyc), 32'd0);
    check_dec("t6_after", 500, 500, 1'b0, 1'b0, 0);

    // Random decimal operations
    for (int i = 0; i < 60; i++) begin
      check_dec("rnd", $urandom_range(9999), $urandom_range(9999),
                1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(2)));
    end

    // Random raw nibbles: only the invalid-digit flag has decimal meaning
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      run_op(ra, rb, 1'($urandom_range(1)), 1'($urandom_range(1)), 0, gs, gc, gb);
      check("rnd_bad", 32'(gb), 32'(any_bad(ra) | any_bad(rb)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
